// File: rtl/memory_match_ctrl.sv
// memory_match_ctrl
//   Card-matching game controller. It latches a shuffled deck from the upstream
//   shuffler and accepts player slot selections. Two selected cards are compared
//   as a pair; ids 2k and 2k+1 belong to pair k. A mismatched pair stays face-up
//   for SHOW_CYCLES cycles before it is turned back down. The controller counts
//   tries and found pairs and raises game_over when every pair is matched.
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   order_valid     strobe: card_order carries a new deck (slot i at [IDX_W*i +: IDX_W])
//   sel_valid/idx   player selection request and the selected slot
//   sel_ready       registered; high only while waiting for a first or second card
//   sel_reject      pulse: a selection was taken but was illegal
//   face_up/matched per-slot shown and permanently-matched flags
//   pair_valid      pulse: a comparison result is available on pair_match
//   pair_match      result of the last comparison (held until the next one)
//   tries           completed comparisons, saturating
//   pairs_found     matched pairs this game
//   deck_err        pulse: the loaded deck held an id >= N_CARDS
//   game_over       all pairs found
module memory_match_ctrl #(
    parameter int N_CARDS     = 20,
    parameter int IDX_W       = 5,
    parameter int TRY_W       = 8,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       order_valid,
    input  logic [N_CARDS*IDX_W-1:0]   card_order,
    input  logic                       sel_valid,
    input  logic [IDX_W-1:0]           sel_idx,
    output logic                       sel_ready,
    output logic                       sel_reject,
    output logic [N_CARDS-1:0]         face_up,
    output logic [N_CARDS-1:0]         matched,
    output logic                       pair_valid,
    output logic                       pair_match,
    output logic [TRY_W-1:0]           tries,
    output logic [IDX_W-1:0]           pairs_found,
    output logic                       deck_err,
    output logic                       game_over
);

    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(N_CARDS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_FIRST  = 3'd1,
        WAIT_SECOND = 3'd2,
        COMPARE     = 3'd3,
        SHOW        = 3'd4,
        DONE        = 3'd5
    } state_t;

    // True when every id in the deck addresses a real card.
    function automatic logic deck_ok(input logic [N_CARDS*IDX_W-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_CARDS; i++) begin
            ok = ok & (d[IDX_W*i +: IDX_W] < IDX_W'(N_CARDS));
        end
        return ok;
    endfunction

    // Card id stored in a slot; loop form keeps every select in range.
    function automatic logic [IDX_W-1:0] card_at(input logic [N_CARDS*IDX_W-1:0] d,
                                                 input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CARDS; i++) begin
            c = (idx == IDX_W'(i)) ? d[IDX_W*i +: IDX_W] : c;
        end
        return c;
    endfunction

    // One-hot slot mask; an out-of-range index yields an empty mask.
    function automatic logic [N_CARDS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_CARDS-1:0] oh;
        for (int i = 0; i < N_CARDS; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // Slot exists, is not shown and is not already matched.
    function automatic logic slot_free(input logic [IDX_W-1:0] idx,
                                       input logic [N_CARDS-1:0] fu,
                                       input logic [N_CARDS-1:0] mt);
        return |(onehot(idx) & ~fu & ~mt);
    endfunction

    state_t                     state_r, state_s;
    logic [N_CARDS*IDX_W-1:0]   deck_r;
    logic [IDX_W-1:0]           first_r, second_r;
    logic [TMR_W-1:0]           timer_r;
    logic                       sel_ready_r, sel_reject_r, pair_valid_r, pair_match_r;
    logic                       deck_err_r, game_over_r;
    logic [N_CARDS-1:0]         face_up_r, matched_r;
    logic [TRY_W-1:0]           tries_r;
    logic [IDX_W-1:0]           pairs_found_r;

    logic                       take_s, free_s, deck_good_s, match_s;
    logic [IDX_W-1:0]           first_id_s, second_id_s;

    assign take_s      = sel_valid & sel_ready_r;
    assign free_s      = slot_free(sel_idx, face_up_r, matched_r);
    assign deck_good_s = deck_ok(card_order);
    assign first_id_s  = card_at(deck_r, first_r);
    assign second_id_s = card_at(deck_r, second_r);
    assign match_s     = (first_id_s >> 1) == (second_id_s >> 1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a deck load overrides whatever the game is doing.
    always_comb begin
        state_s = state_r;
        if (order_valid) begin
            state_s = deck_good_s ? WAIT_FIRST : IDLE;
        end else begin
            case (state_r)
                IDLE:        state_s = IDLE;
                WAIT_FIRST:  state_s = (take_s && free_s) ? WAIT_SECOND : WAIT_FIRST;
                WAIT_SECOND: state_s = (take_s && free_s && (sel_idx != first_r)) ? COMPARE : WAIT_SECOND;
                COMPARE: begin
                    if (match_s) begin
                        state_s = (pairs_found_r == LAST_PAIR) ? DONE : WAIT_FIRST;
                    end else begin
                        state_s = SHOW;
                    end
                end
                SHOW:        state_s = (timer_r == '0) ? WAIT_FIRST : SHOW;
                DONE:        state_s = DONE;
                default:     state_s = IDLE;
            endcase
        end
    end

    // Game datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            deck_r        <= '0;
            first_r       <= '0;
            second_r      <= '0;
            timer_r       <= '0;
            sel_ready_r   <= 1'b0;
            sel_reject_r  <= 1'b0;
            pair_valid_r  <= 1'b0;
            pair_match_r  <= 1'b0;
            deck_err_r    <= 1'b0;
            game_over_r   <= 1'b0;
            face_up_r     <= '0;
            matched_r     <= '0;
            tries_r       <= '0;
            pairs_found_r <= '0;
        end else begin
            // sel_ready mirrors the state being entered so it is never stale.
            sel_ready_r  <= (state_s == WAIT_FIRST) || (state_s == WAIT_SECOND);
            sel_reject_r <= 1'b0;
            pair_valid_r <= 1'b0;
            deck_err_r   <= 1'b0;
            if (order_valid) begin
                deck_r        <= card_order;
                deck_err_r    <= ~deck_good_s;
                first_r       <= '0;
                second_r      <= '0;
                timer_r       <= '0;
                face_up_r     <= '0;
                matched_r     <= '0;
                tries_r       <= '0;
                pairs_found_r <= '0;
                game_over_r   <= 1'b0;
                pair_match_r  <= 1'b0;
            end else begin
                case (state_r)
                    WAIT_FIRST: begin
                        if (take_s && free_s) begin
                            face_up_r <= face_up_r | onehot(sel_idx);
                            first_r   <= sel_idx;
                        end else begin
                            sel_reject_r <= take_s;
                        end
                    end
                    WAIT_SECOND: begin
                        if (take_s && free_s && (sel_idx != first_r)) begin
                            face_up_r <= face_up_r | onehot(sel_idx);
                            second_r  <= sel_idx;
                        end else begin
                            sel_reject_r <= take_s;
                        end
                    end
                    COMPARE: begin
                        pair_valid_r <= 1'b1;
                        pair_match_r <= match_s;
                        if (tries_r != {TRY_W{1'b1}}) begin
                            tries_r <= tries_r + TRY_W'(1);
                        end else begin
                            tries_r <= tries_r;
                        end
                        if (match_s) begin
                            matched_r     <= matched_r | onehot(first_r) | onehot(second_r);
                            pairs_found_r <= pairs_found_r + IDX_W'(1);
                            game_over_r   <= (pairs_found_r == LAST_PAIR);
                        end else begin
                            timer_r <= SHOW_LOAD;
                        end
                    end
                    SHOW: begin
                        if (timer_r == '0) begin
                            face_up_r <= face_up_r & ~(onehot(first_r) | onehot(second_r));
                        end else begin
                            timer_r <= timer_r - TMR_W'(1);
                        end
                    end
                    default: begin
                        timer_r <= timer_r;
                    end
                endcase
            end
        end
    end

    assign sel_ready   = sel_ready_r;
    assign sel_reject  = sel_reject_r;
    assign face_up     = face_up_r;
    assign matched     = matched_r;
    assign pair_valid  = pair_valid_r;
    assign pair_match  = pair_match_r;
    assign tries       = tries_r;
    assign pairs_found = pairs_found_r;
    assign deck_err    = deck_err_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_memory_match_ctrl.sv
module tb_memory_match_ctrl;

    localparam int N  = 20;
    localparam int IW = 5;
    localparam int TW = 8;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            order_valid = 1'b0;
    logic [N*IW-1:0] card_order = '0;
    logic            sel_valid = 1'b0;
    logic [IW-1:0]   sel_idx = '0;
    logic            sel_ready, sel_reject, pair_valid, pair_match, deck_err, game_over;
    logic [N-1:0]    face_up, matched;
    logic [TW-1:0]   tries;
    logic [IW-1:0]   pairs_found;

    memory_match_ctrl #(.N_CARDS(N), .IDX_W(IW), .TRY_W(TW), .SHOW_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .order_valid(order_valid), .card_order(card_order),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_ready(sel_ready),
        .sel_reject(sel_reject), .face_up(face_up), .matched(matched),
        .pair_valid(pair_valid), .pair_match(pair_match), .tries(tries),
        .pairs_found(pairs_found), .deck_err(deck_err), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference game state, kept as plain arrays and integers.
    int           deck_in[N];
    int           deck_m[N];
    logic [N-1:0] face_m, matched_m;
    int           tries_m, pairs_m, first_m;
    bit           have_first;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_m(input int idx);
        if (idx < 0 || idx >= N) return 1'b0;
        if (face_m[idx] || matched_m[idx]) return 1'b0;
        if (have_first && idx == first_m) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_sel_ready", sel_ready, 32'd0);
        check_eq("rst_outputs", {sel_reject, pair_valid, pair_match, deck_err, game_over}, 32'd0);
        check_eq("rst_face_up", face_up, 32'd0);
        check_eq("rst_matched", matched, 32'd0);
        check_eq("rst_counts", {tries, pairs_found}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sel_valid = 1'b1;
        sel_idx = 5'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("idle_no_reject", sel_reject, 32'd0);
            check_eq("idle_not_ready", sel_ready, 32'd0);
            check_eq("idle_face_up", face_up, 32'd0);
        end
        @(negedge clk);
        sel_valid = 1'b0;
        have_first = 1'b0;
    endtask

    task automatic load_deck(input bit with_sel);
        logic [N*IW-1:0] co;
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            co[IW*i +: IW] = deck_in[i][IW-1:0];
            if (deck_in[i] >= N) bad = 1'b1;
        end
        @(negedge clk);
        order_valid = 1'b1;
        card_order = co;
        sel_valid = with_sel;
        sel_idx = 5'd0;
        @(posedge clk);
        #1;
        check_eq("deck_err", deck_err, bad);
        check_eq("ready_after_load", sel_ready, !bad);
        check_eq("load_no_reject", sel_reject, 32'd0);
        if (!bad) begin
            deck_m = deck_in;
            face_m = '0;
            matched_m = '0;
            tries_m = 0;
            pairs_m = 0;
            have_first = 1'b0;
            check_eq("load_face_up", face_up, 32'd0);
            check_eq("load_counts", {tries, pairs_found, game_over}, 32'd0);
        end
        @(negedge clk);
        order_valid = 1'b0;
        sel_valid = 1'b0;
    endtask

    task automatic pick(input int idx, input bit stop_in_show);
        int n;
        int s;
        bit lg;
        bit m;
        n = 0;
        @(negedge clk);
        while (sel_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_pick", sel_ready, 32'd1);
        lg = legal_m(idx);
        sel_valid = 1'b1;
        sel_idx = idx[IW-1:0];
        @(posedge clk);
        #1;
        check_eq("sel_reject", sel_reject, !lg);
        check_eq("no_early_pair_valid", pair_valid, 32'd0);
        check_eq("tries_at_pick", tries, tries_m);
        if (lg) face_m[idx] = 1'b1;
        check_eq("face_up_after_pick", face_up, face_m);
        @(negedge clk);
        sel_valid = 1'b0;
        if (!lg) return;
        if (!have_first) begin
            have_first = 1'b1;
            first_m = idx;
            return;
        end
        s = idx;
        have_first = 1'b0;
        @(posedge clk);
        #1;
        m = (deck_m[first_m] / 2) == (deck_m[s] / 2);
        if (tries_m < (1 << TW) - 1) tries_m++;
        check_eq("pair_valid", pair_valid, 32'd1);
        check_eq("pair_match", pair_match, m);
        check_eq("tries", tries, tries_m);
        if (m) begin
            matched_m[first_m] = 1'b1;
            matched_m[s] = 1'b1;
            pairs_m++;
            check_eq("matched", matched, matched_m);
            check_eq("pairs_found", pairs_found, pairs_m);
            check_eq("game_over", game_over, pairs_m == N / 2);
            check_eq("ready_after_match", sel_ready, pairs_m != N / 2);
            check_eq("face_up_after_match", face_up, face_m);
        end else begin
            check_eq("ready_in_show", sel_ready, 32'd0);
            check_eq("face_up_in_show", face_up, face_m);
            if (stop_in_show) return;
            n = 0;
            while (sel_ready !== 1'b1 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_eq("show_len", n, SC);
            face_m[first_m] = 1'b0;
            face_m[s] = 1'b0;
            check_eq("face_up_after_show", face_up, face_m);
            check_eq("pair_match_held", pair_match, 32'd0);
        end
    endtask

    initial begin
        int idx;
        int r;
        int k;
        int tmp;
        do_reset();

        // Identity deck: match, mismatch, illegal picks, then mid-game reset.
        for (int i = 0; i < N; i++) deck_in[i] = i;
        load_deck(1'b0);
        pick(0, 1'b0); pick(1, 1'b0);
        pick(2, 1'b0); pick(4, 1'b0);
        pick(3, 1'b0); pick(3, 1'b0); pick(25, 1'b0); pick(0, 1'b0);
        pick(2, 1'b0);
        do_reset();

        // Full game in slot order.
        load_deck(1'b1);
        for (int i = 0; i < N; i++) pick(i, 1'b0);
        check_eq("final_matched", matched, 32'hFFFFF);
        check_eq("final_face_up", face_up, 32'hFFFFF);
        check_eq("final_tries", tries, 32'd10);
        @(negedge clk);
        sel_valid = 1'b1;
        sel_idx = 5'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("done_not_ready", sel_ready, 32'd0);
            check_eq("done_no_reject", sel_reject, 32'd0);
            check_eq("done_game_over", game_over, 32'd1);
        end
        @(negedge clk);
        sel_valid = 1'b0;

        // Bad deck, then reload during SHOW and during WAIT_FIRST.
        deck_in[7] = 31;
        load_deck(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bad_deck_idle", sel_ready, 32'd0);
        check_eq("deck_err_pulse", deck_err, 32'd0);
        deck_in[7] = 7;
        load_deck(1'b0);
        pick(0, 1'b0); pick(2, 1'b1);
        for (int i = 0; i < N; i++) deck_in[i] = N - 1 - i;
        load_deck(1'b1);
        pick(19, 1'b0); pick(18, 1'b0);
        pick(17, 1'b0); pick(15, 1'b0);
        load_deck(1'b1);
        pick(0, 1'b0); pick(1, 1'b0);

        // Randomised games on shuffled decks.
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < N; i++) deck_in[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                k = $urandom_range(0, i);
                tmp = deck_in[i];
                deck_in[i] = deck_in[k];
                deck_in[k] = tmp;
            end
            load_deck($urandom_range(0, 1));
            for (int p = 0; p < 500 && pairs_m < N / 2; p++) begin
                r = $urandom_range(0, 99);
                idx = $urandom_range(0, 23);
                if (have_first && g > 0 && r < 40) begin
                    for (int j = 0; j < N; j++) begin
                        if (j != first_m && deck_m[j] / 2 == deck_m[first_m] / 2) idx = j;
                    end
                end
                pick(idx, 1'b0);
            end
            check_eq("rand_pairs", pairs_found, pairs_m);
            check_eq("rand_matched", matched, matched_m);
            check_eq("rand_game_over", game_over, pairs_m == N / 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
